// File: rtl/scoreboard.sv
// Register scoreboard: per-register in-flight writer counters block issue on RAW and counter-saturation hazards.
// A RUN/STALL/DRAIN FSM drives stop/bubble; a flush drains until every counter reads zero.
module scoreboard #(
  parameter int NREG  = 32,
  parameter int CNT_W = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    issue_valid,
  input  logic [$clog2(NREG)-1:0] rs1,
  input  logic [$clog2(NREG)-1:0] rs2,
  input  logic                    rs1_used,
  input  logic                    rs2_used,
  input  logic [$clog2(NREG)-1:0] rd,
  input  logic                    rd_wen,
  input  logic                    wb_valid,
  input  logic [$clog2(NREG)-1:0] wb_rd,
  input  logic                    flush,
  output logic                    issue_ready,
  output logic                    stop,
  output logic                    bubble,
  output logic [NREG-1:0]         busy_mask,
  output logic [1:0]              state,
  output logic [31:0]             stall_cnt,
  output logic                    err
);
  typedef enum logic [1:0] {RUN = 2'd0, STALL = 2'd1, DRAIN = 2'd2} state_t;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t           cur, nxt;
  logic [CNT_W-1:0] cnt [NREG];
  logic             hazard, do_inc, err_set;
  logic [NREG-1:0]  inc_sel, wb_sel;

  always_comb begin
    busy_mask = '0;
    for (int i = 1; i < NREG; i++) busy_mask[i] = (cnt[i] != '0);
  end

  // Hazard looks at registered counters only; a writeback frees its register one cycle later.
  assign hazard = (rs1_used && rs1 != '0 && cnt[rs1] != '0)
               || (rs2_used && rs2 != '0 && cnt[rs2] != '0)
               || (rd_wen   && rd  != '0 && cnt[rd]  == CNT_MAX);

  assign issue_ready = !reset && issue_valid && !hazard && !flush && cur != DRAIN;
  assign stop        = !reset && ((issue_valid && !issue_ready) || cur == DRAIN || flush);
  assign bubble      = stop;
  assign state       = cur;

  assign do_inc  = issue_ready && rd_wen && rd != '0;
  assign inc_sel = do_inc ? (NREG'(1) << rd) : '0;
  assign wb_sel  = (wb_valid && wb_rd != '0) ? (NREG'(1) << wb_rd) : '0;
  // A writeback landing on a register being issued this same edge cancels out rather than erroring.
  assign err_set = wb_valid && wb_rd != '0 && cnt[wb_rd] == '0 && !inc_sel[wb_rd];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NREG; i++) cnt[i] <= '0;
    end else begin
      for (int i = 1; i < NREG; i++) begin
        if (inc_sel[i] && !wb_sel[i])
          cnt[i] <= cnt[i] + 1'b1;
        else if (wb_sel[i] && !inc_sel[i] && cnt[i] != '0)
          cnt[i] <= cnt[i] - 1'b1;
      end
    end
  end

  always_comb begin
    nxt = cur;
    case (cur)
      RUN:     if (flush) nxt = DRAIN; else if (issue_valid && hazard) nxt = STALL;
      STALL:   if (flush) nxt = DRAIN; else if (!issue_valid || !hazard) nxt = RUN;
      DRAIN:   if (!flush && busy_mask == '0) nxt = RUN;
      default: nxt = RUN;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cur       <= RUN;
      stall_cnt <= '0;
      err       <= 1'b0;
    end else begin
      cur <= nxt;
      if (stop && stall_cnt != '1) stall_cnt <= stall_cnt + 1'b1;
      if (err_set) err <= 1'b1;
    end
  end
endmodule

// File: tb/tb_scoreboard.sv
// Self-checking bench for scoreboard: directed hazard/flush/reset scenarios plus random traffic vs. a counter-array model.
module tb_scoreboard;
  logic        clk = 1'b0;
  logic        reset;
  logic        issue_valid, rs1_used, rs2_used, rd_wen, wb_valid, flush;
  logic [4:0]  rs1, rs2, rd, wb_rd;
  logic        issue_ready, stop, bubble, err;
  logic [31:0] busy_mask, stall_cnt;
  logic [1:0]  state;

  int n_checks = 0;
  int n_pass   = 0;

  // Model: in-flight writer count per register, FSM state as an int, stall counter, sticky error.
  int          m_cnt [32];
  int          m_state;
  logic [31:0] m_stall;
  bit          m_err;

  scoreboard #(.NREG(32), .CNT_W(2)) dut (
    .clk(clk), .reset(reset), .issue_valid(issue_valid),
    .rs1(rs1), .rs2(rs2), .rs1_used(rs1_used), .rs2_used(rs2_used),
    .rd(rd), .rd_wen(rd_wen), .wb_valid(wb_valid), .wb_rd(wb_rd), .flush(flush),
    .issue_ready(issue_ready), .stop(stop), .bubble(bubble),
    .busy_mask(busy_mask), .state(state), .stall_cnt(stall_cnt), .err(err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  function automatic void m_reset();
    for (int i = 0; i < 32; i++) m_cnt[i] = 0;
    m_state = 0;
    m_stall = 0;
    m_err   = 0;
  endfunction

  function automatic bit m_hazard();
    return (rs1_used && rs1 != 0 && m_cnt[rs1] != 0)
        || (rs2_used && rs2 != 0 && m_cnt[rs2] != 0)
        || (rd_wen   && rd  != 0 && m_cnt[rd]  == 3);
  endfunction

  function automatic logic [31:0] m_busy();
    logic [31:0] b = '0;
    for (int i = 1; i < 32; i++) b[i] = (m_cnt[i] != 0);
    return b;
  endfunction

  task automatic set(input bit iv, input int r1, input bit u1, input int r2, input bit u2,
                     input int d, input bit w, input bit wv, input int wr, input bit fl);
    issue_valid = iv; rs1 = 5'(r1); rs1_used = u1; rs2 = 5'(r2); rs2_used = u2;
    rd = 5'(d); rd_wen = w; wb_valid = wv; wb_rd = 5'(wr); flush = fl;
  endtask

  // One cycle: compare all outputs against the model, clock, then advance the model.
  task automatic step();
    bit hz, rdy, stp, all0, cancel;
    int nxt, inc_r;
    #1;
    hz   = m_hazard();
    rdy  = issue_valid && !hz && !flush && m_state != 2;
    stp  = (issue_valid && !rdy) || m_state == 2 || flush;
    all0 = (m_busy() == 0);
    check("issue_ready", {31'b0, issue_ready}, {31'b0, rdy});
    check("stop",        {31'b0, stop},        {31'b0, stp});
    check("bubble",      {31'b0, bubble},      {31'b0, stp});
    check("busy_mask",   busy_mask,            m_busy());
    check("state",       {30'b0, state},       32'(m_state));
    check("stall_cnt",   stall_cnt,            m_stall);
    check("err",         {31'b0, err},         {31'b0, m_err});
    @(posedge clk);
    nxt = m_state;
    if (flush) nxt = 2;
    else if (m_state == 0 && issue_valid && hz) nxt = 1;
    else if (m_state == 1 && (!issue_valid || !hz)) nxt = 0;
    else if (m_state == 2 && all0) nxt = 0;
    m_state = nxt;
    inc_r  = (rdy && rd_wen && rd != 0) ? int'(rd) : 0;
    cancel = inc_r != 0 && wb_valid && int'(wb_rd) == inc_r;
    if (!cancel) begin
      if (inc_r != 0) m_cnt[inc_r]++;
      if (wb_valid && wb_rd != 0) begin
        if (m_cnt[wb_rd] > 0) m_cnt[wb_rd]--;
        else m_err = 1;
      end
    end
    if (stp && m_stall != 32'hFFFF_FFFF) m_stall++;
    @(negedge clk);
  endtask

  task automatic cyc(input bit iv, input int r1, input bit u1, input int r2, input bit u2,
                     input int d, input bit w, input bit wv, input int wr, input bit fl);
    set(iv, r1, u1, r2, u2, d, w, wv, wr, fl);
    step();
  endtask

  initial begin
    logic [31:0] s0;
    // Reset with pressure on every input: outputs must be quiet.
    reset = 1'b1;
    set(1, 1, 1, 2, 1, 3, 1, 1, 4, 1);
    m_reset();
    #3;
    check("rst_issue_ready", {31'b0, issue_ready}, 32'd0);
    check("rst_stop",        {31'b0, stop},        32'd0);
    check("rst_busy",        busy_mask,            32'd0);
    check("rst_state",       {30'b0, state},       32'd0);
    @(negedge clk);
    reset = 1'b0;
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    // RAW on x5, released by a writeback
    cyc(1, 0, 0, 0, 0, 5, 1, 0, 0, 0);
    cyc(1, 5, 1, 0, 0, 6, 0, 0, 0, 0);
    check("raw_state_stall", {30'b0, state}, 32'd1);
    cyc(1, 5, 1, 0, 0, 6, 0, 0, 0, 0);
    cyc(1, 5, 1, 0, 0, 6, 0, 1, 5, 0);
    set(1, 5, 1, 0, 0, 6, 0, 0, 0, 0);
    #1;
    check("raw_ready_after_wb", {31'b0, issue_ready}, 32'd1);
    check("raw_busy5_clear",    {31'b0, busy_mask[5]}, 32'd0);
    step();

    // Three writers of x7 saturate its counter
    repeat (3) cyc(1, 0, 0, 0, 0, 7, 1, 0, 0, 0);
    set(1, 0, 0, 0, 0, 7, 1, 0, 0, 0);
    #1;
    check("sat_fourth_blocked", {31'b0, issue_ready}, 32'd0);
    step();
    cyc(1, 0, 0, 0, 0, 7, 1, 1, 7, 0);
    set(1, 0, 0, 0, 0, 7, 1, 0, 0, 0);
    #1;
    check("sat_fourth_accepted", {31'b0, issue_ready}, 32'd1);
    step();
    repeat (3) cyc(0, 0, 0, 0, 0, 0, 0, 1, 7, 0);

    // Issue and writeback of x9 on the same edge
    cyc(1, 0, 0, 0, 0, 9, 1, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 9, 1, 1, 9, 0);
    check("simul_busy9", {31'b0, busy_mask[9]}, 32'd1);
    check("simul_err",   {31'b0, err},          32'd0);
    cyc(0, 0, 0, 0, 0, 0, 0, 1, 9, 0);

    // x0 is never tracked
    repeat (4) begin
      set(1, 0, 1, 0, 1, 0, 1, 1, 0, 0);
      #1;
      check("x0_no_stop", {31'b0, stop}, 32'd0);
      step();
    end

    // Flush with x3 x2 and x4 x1 in flight
    cyc(1, 0, 0, 0, 0, 3, 1, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 3, 1, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 4, 1, 0, 0, 0);
    s0 = m_stall;
    set(1, 0, 0, 0, 0, 3, 1, 0, 0, 1);
    #1;
    check("flush_not_accepted", {31'b0, issue_ready}, 32'd0);
    step();
    check("flush_drain", {30'b0, state}, 32'd2);
    cyc(1, 0, 0, 0, 0, 1, 1, 1, 3, 0);
    cyc(0, 0, 0, 0, 0, 0, 0, 1, 3, 0);
    cyc(0, 0, 0, 0, 0, 0, 0, 1, 4, 0);
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    check("flush_back_to_run", {30'b0, state}, 32'd0);
    check("flush_stall_cnt",   stall_cnt,      s0 + 32'd5);

    // Random traffic over a small register window
    for (int k = 0; k < 400; k++) begin
      int wr;
      wr = $urandom_range(0, 7);
      if ($urandom_range(0, 1) == 1)
        for (int j = 1; j < 8; j++) if (m_cnt[j] != 0) wr = j;
      cyc($urandom_range(0, 3) != 0, $urandom_range(0, 7), $urandom_range(0, 1) == 1,
          $urandom_range(0, 7), $urandom_range(0, 1) == 1, $urandom_range(0, 7),
          $urandom_range(0, 1) == 1, $urandom_range(0, 2) != 0, wr, $urandom_range(0, 40) == 0);
    end

    // Writeback to an idle register sets a sticky error, cleared only by reset
    @(posedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    m_reset();
    cyc(0, 0, 0, 0, 0, 0, 0, 1, 12, 0);
    cyc(1, 0, 0, 0, 0, 13, 1, 0, 0, 0);
    check("err_sticky", {31'b0, err}, 32'd1);
    cyc(1, 13, 1, 0, 0, 0, 0, 0, 0, 0);
    set(1, 13, 1, 0, 0, 0, 0, 0, 0, 0);
    #2;
    reset = 1'b1;
    #1;
    check("midrst_err",   {31'b0, err},   32'd0);
    check("midrst_stall", stall_cnt,      32'd0);
    check("midrst_state", {30'b0, state}, 32'd0);
    check("midrst_busy",  busy_mask,      32'd0);
    @(negedge clk);
    reset = 1'b0;
    m_reset();
    cyc(1, 13, 1, 0, 0, 13, 1, 0, 0, 0);
    cyc(1, 13, 1, 0, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0, 1, 13, 0);
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
